pad_reader: RTL and testbench
=============================

# pad_reader

Parametrised multi-port reader for NES/SNES-style serial game pads. It generates a shared latch and pulse to up to NUM_PADS controllers, shifts in BITS button bits per pad, and publishes an active-high button vector, a one-cycle valid strobe and per-button new-press flags. It sits between the pad connector pins and the game logic, and is the parametrised successor of the single-pad, fixed 8-bit input controller.

## Interface
- NUM_PADS, 2: number of controller ports sharing latch and pulse.
- BITS, 8: button bits per pad (8 = NES, 16 = SNES); minimum 2.
- LATCH_CYCLES, 600: latch high time in clk cycles (12 us at 50 MHz).
- HALF_CYCLES, 300: pulse half-period in clk cycles (6 us at 50 MHz).
- POLL_CYCLES, 833333: free-running poll period in clk cycles (60 Hz).

- clk  in  1  50 MHz system clock.
- reset_n  in  1  asynchronous, active-low reset.
- poll_en  in  1  enables periodic polling.
- poll_now  in  1  one-cycle request for an immediate poll.
- pad_data  in  NUM_PADS  serial data per pad; low = pressed. Pre-synchronised externally.
- pad_latch  out  1  shared latch, active high.
- pad_pulse  out  1  shared shift pulse, active high.
- buttons  out  NUM_PADS*BITS  pad p, bit k at [p*BITS+k]; 1 = held.
- pressed  out  NUM_PADS*BITS  1 for bits that went 0->1 in this frame; valid with buttons_valid.
- buttons_valid  out  1  one-cycle strobe when buttons and pressed update.
- busy  out  1  high while a frame is in progress (any state except IDLE).

## Operation
- FSM states: IDLE, LATCH, PULSE_LO, PULSE_HI, DONE.
- IDLE: latch=0, pulse=0. Leaves for LATCH when the request flag is set.
- Request flag: set by poll-timer tick (when poll_en=1) or by poll_now. It is cleared on entry to LATCH. At most one request is pending; extra requests while it is already set are dropped.
- Poll timer: counts 0..POLL_CYCLES-1, wraps, and ticks on the wrap cycle. It runs regardless of FSM state and holds at 0 while poll_en=0.
- LATCH: latch=1 for LATCH_CYCLES. On the last cycle, sample bit 0 of every pad.
- PULSE_LO / PULSE_HI: pulse=0, then pulse=1, each for HALF_CYCLES. On the last cycle of PULSE_HI, sample bit k (k = 1..BITS-1). After bit BITS-1 is sampled, go to DONE; otherwise go to PULSE_LO. There are exactly BITS-1 pulses per frame.
- Sampled bits are stored inverted, so pressed = 1.
- DONE (1 cycle): register new buttons, pressed = new & ~previous buttons, assert buttons_valid on the following cycle, then return to IDLE.
- Counter widths: $clog2 of the largest count. The bit index is $clog2(BITS) wide.

## Timing
- Reset values: pad_latch=0, pad_pulse=0, buttons=0, pressed=0, buttons_valid=0, busy=0, FSM=IDLE, poll counter=0, request flag=0.
- S = first cycle with pad_latch=1, which is 1 cycle after the request is set in IDLE.
- Bit k is sampled at S+LATCH_CYCLES+2*k*HALF_CYCLES-1.
- buttons_valid is high at S+LATCH_CYCLES+2*(BITS-1)*HALF_CYCLES+1.
- buttons and pressed change only on that cycle. pressed is meaningful only while buttons_valid=1 and is held otherwise.
- Request arriving while busy: serviced immediately after DONE. No frame is ever truncated.
- poll_now and timer tick in the same cycle: one request.
- reset_n asserted mid-frame: all state returns to reset values immediately. The partial frame is discarded and no valid strobe is issued.

## Configuration
- PAD_DEBOUNCE_EN defined: a bit of buttons changes only when the sampled value matches the value sampled in the previous frame. pressed is derived from the debounced buttons. The raw previous frame is held per pad, and the first frame after reset only primes it.
- Not defined: buttons takes the raw sampled frame directly.

## Structure
- Package pad_reader_pkg holds:
  - FSM state enum.
  - Constants NES_BITS=8 and SNES_BITS=16.
  - Default timing constants for 50 MHz.
- Sub-module pad_shift_chan, instantiated NUM_PADS times: per-pad shift register, debounce (under PAD_DEBOUNCE_EN), previous-frame register and press-edge logic. It is driven by shared sample and commit strobes from the top-level FSM.

## Test plan
All scenarios use NUM_PADS=2, BITS=8, LATCH_CYCLES=4, HALF_CYCLES=2, POLL_CYCLES=100.
- **Idle pads:** pad_data=2'b11, poll_en=1 -> buttons_valid 33 cycles after latch rise; buttons=0, pressed=0; 7 pulses per frame.
- **Per-pad bit mapping:** pad0 drives 0 only in bit-0 slot (A), pad1 drives 0 only in bit-7 slot (Right) -> buttons=16'h8001, pressed=16'h8001.
- **Held button:** same stimulus for the next frame -> buttons=16'h8001, pressed=0. Release on the third frame -> buttons=0, pressed=0.
- **Overlapping requests:** poll_now pulsed twice during a busy frame -> exactly one extra frame starts 1 cycle after DONE, and no frame is truncated.
- **Reset mid-frame:** reset_n low during PULSE_HI of bit 3 -> latch/pulse/buttons/busy=0 immediately, no buttons_valid; after release, the next tick produces a full frame.
- **Debounce (PAD_DEBOUNCE_EN):** pad0 bit-2 pressed for one frame only -> buttons bit 2 stays 0. Held for two frames -> it sets on the second frame with pressed bit 2 = 1.

Source files
------------

// File: rtl/pad_reader_pkg.sv
// pad_reader_pkg: shared FSM state type, pad bit counts and 50 MHz default timing.
package pad_reader_pkg;
    typedef enum logic [2:0] {IDLE, LATCH, PULSE_LO, PULSE_HI, DONE} state_e;
    localparam int NES_BITS         = 8;
    localparam int SNES_BITS        = 16;
    localparam int DEF_LATCH_CYCLES = 600;
    localparam int DEF_HALF_CYCLES  = 300;
    localparam int DEF_POLL_CYCLES  = 833333;
endpackage

// File: rtl/pad_shift_chan.sv
// pad_shift_chan: per-pad shift register, previous-frame register and press-edge flags.
// Defining PAD_DEBOUNCE_EN only lets a bit change once two consecutive frames agree.
module pad_shift_chan
    import pad_reader_pkg::*;
#(
    parameter int BITS = NES_BITS
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            data_in,
    input  logic            sample,
    input  logic            commit,
    output logic [BITS-1:0] buttons,
    output logic [BITS-1:0] pressed
);
    logic [BITS-1:0] shift_q, shift_d, buttons_q, buttons_d, pressed_q, pressed_d;
`ifdef PAD_DEBOUNCE_EN
    logic [BITS-1:0] prev_q, prev_d, stable;
    logic            primed_q, primed_d;
    always_comb begin
        stable    = ~(shift_q ^ prev_q);
        prev_d    = commit ? shift_q : prev_q;
        primed_d  = primed_q | commit;
        // the first frame after reset only primes the raw history
        buttons_d = (commit && primed_q) ? (shift_q & stable) | (buttons_q & ~stable) : buttons_q;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q   <= '0;
            primed_q <= 1'b0;
        end else begin
            prev_q   <= prev_d;
            primed_q <= primed_d;
        end
    end
`else
    assign buttons_d = commit ? shift_q : buttons_q;
`endif
    // bit 0 arrives first, so shifting right leaves it at [0] after BITS samples
    always_comb begin
        shift_d   = sample ? {~data_in, shift_q[BITS-1:1]} : shift_q;
        pressed_d = commit ? buttons_d & ~buttons_q : pressed_q;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_q   <= '0;
            buttons_q <= '0;
            pressed_q <= '0;
        end else begin
            shift_q   <= shift_d;
            buttons_q <= buttons_d;
            pressed_q <= pressed_d;
        end
    end
    assign buttons = buttons_q;
    assign pressed = pressed_q;
endmodule

// File: rtl/pad_reader.sv
// pad_reader: polls NUM_PADS serial game pads over a shared latch/pulse and publishes buttons.
// Optional PAD_DEBOUNCE_EN (see pad_shift_chan) filters single-frame glitches.
module pad_reader
    import pad_reader_pkg::*;
#(
    parameter int NUM_PADS     = 2,
    parameter int BITS         = NES_BITS,
    parameter int LATCH_CYCLES = DEF_LATCH_CYCLES,
    parameter int HALF_CYCLES  = DEF_HALF_CYCLES,
    parameter int POLL_CYCLES  = DEF_POLL_CYCLES
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     poll_en,
    input  logic                     poll_now,
    input  logic [NUM_PADS-1:0]      pad_data,
    output logic                     pad_latch,
    output logic                     pad_pulse,
    output logic [NUM_PADS*BITS-1:0] buttons,
    output logic [NUM_PADS*BITS-1:0] pressed,
    output logic                     buttons_valid,
    output logic                     busy
);
    localparam int MAXC = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int PW   = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam int IW   = $clog2(BITS);
    localparam logic [CW-1:0] L_LAST   = CW'(LATCH_CYCLES - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(HALF_CYCLES - 1);
    localparam logic [PW-1:0] P_LAST   = PW'(POLL_CYCLES - 1);
    localparam logic [IW-1:0] BIT_LAST = IW'(BITS - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] poll_q, poll_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          req_q, req_d, valid_q, valid_d;
    logic          tick, sample, commit;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sample  = 1'b0;
        commit  = 1'b0;
        tick    = poll_en && poll_q == P_LAST;
        poll_d  = (!poll_en || tick) ? '0 : poll_q + 1'b1;
        req_d   = req_q | tick | poll_now;
        case (state_q)
            IDLE: if (req_q) begin
                state_d = LATCH;
                cnt_d   = '0;
                req_d   = 1'b0;
            end
            LATCH: if (cnt_q == L_LAST) begin
                sample  = 1'b1;
                state_d = PULSE_LO;
                cnt_d   = '0;
                idx_d   = IW'(1);
            end else cnt_d = cnt_q + 1'b1;
            PULSE_LO: if (cnt_q == H_LAST) begin
                state_d = PULSE_HI;
                cnt_d   = '0;
            end else cnt_d = cnt_q + 1'b1;
            PULSE_HI: if (cnt_q == H_LAST) begin
                sample  = 1'b1;
                cnt_d   = '0;
                state_d = (idx_q == BIT_LAST) ? DONE : PULSE_LO;
                idx_d   = (idx_q == BIT_LAST) ? idx_q : idx_q + 1'b1;
            end else cnt_d = cnt_q + 1'b1;
            DONE: begin
                commit  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        valid_d = commit;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            poll_q  <= '0;
            idx_q   <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            poll_q  <= poll_d;
            idx_q   <= idx_d;
            req_q   <= req_d;
            valid_q <= valid_d;
        end
    end

    assign pad_latch     = state_q == LATCH;
    assign pad_pulse     = state_q == PULSE_HI;
    assign busy          = state_q != IDLE;
    assign buttons_valid = valid_q;

    for (genvar p = 0; p < NUM_PADS; p++) begin : g_chan
        pad_shift_chan #(.BITS(BITS)) u_chan (
            .clk     (clk),
            .reset_n (reset_n),
            .data_in (pad_data[p]),
            .sample  (sample),
            .commit  (commit),
            .buttons (buttons[p*BITS +: BITS]),
            .pressed (pressed[p*BITS +: BITS])
        );
    end
endmodule

// File: tb/tb_pad_reader.sv
// tb_pad_reader: emulated serial pads feed the DUT; a monitor scores each frame against a queue.
module tb_pad_reader;
    localparam int NP  = 2;
    localparam int NB  = 8;
    localparam int LC  = 4;
    localparam int HC  = 2;
    localparam int PC  = 100;
    localparam int W   = NP * NB;
    localparam int LAT = LC + 2 * (NB - 1) * HC + 1;

    logic          clk = 1'b0, reset_n = 1'b0, poll_en = 1'b0, poll_now = 1'b0;
    logic [NP-1:0] pad_data;
    logic          pad_latch, pad_pulse, buttons_valid, busy;
    logic [W-1:0]  buttons, pressed;

    pad_reader #(.NUM_PADS(NP), .BITS(NB), .LATCH_CYCLES(LC), .HALF_CYCLES(HC), .POLL_CYCLES(PC)) dut (
        .clk(clk), .reset_n(reset_n), .poll_en(poll_en), .poll_now(poll_now), .pad_data(pad_data),
        .pad_latch(pad_latch), .pad_pulse(pad_pulse), .buttons(buttons), .pressed(pressed),
        .buttons_valid(buttons_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int           errors = 0, checks = 0;
    int           cyc = 0, idx = 0, pulses = 0, frames = 0, nvalid = 0;
    int           start_cyc = 0, valid_cyc = 0;
    logic         latch_prev = 1'b0, pulse_prev = 1'b0;
    logic [W-1:0] held = '0, snap = '0, m_btn = '0, m_raw = '0;
    logic [NP-1:0] m_primed = '0;
    logic [W-1:0] expq[$];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // an NES-style pad: latch loads the held buttons, each pulse rise advances one bit, low = pressed
    always_comb
        for (int p = 0; p < NP; p++) pad_data[p] = (idx < NB) ? ~snap[p*NB + idx] : 1'b0;

    always @(negedge clk) begin
        logic [W-1:0] raw, nb;
        cyc++;
        if (!reset_n) begin
            expq.delete();
            m_btn = '0; m_raw = '0; m_primed = '0;
            latch_prev = 1'b0; pulse_prev = 1'b0;
        end else begin
            if (pad_latch && !latch_prev) begin
                snap = held; idx = 0; pulses = 0; start_cyc = cyc; frames++;
                expq.push_back(held);
            end
            if (pad_pulse && !pulse_prev) begin
                idx++; pulses++;
            end
            if (buttons_valid) begin
                nvalid++; valid_cyc = cyc;
                if (expq.size() == 0) check("unexpected_valid", 1, 0);
                else begin
                    raw = expq.pop_front();
                    nb  = raw;
`ifdef PAD_DEBOUNCE_EN
                    for (int p = 0; p < NP; p++) begin
                        for (int k = 0; k < NB; k++)
                            nb[p*NB+k] = (m_primed[p] && raw[p*NB+k] == m_raw[p*NB+k]) ? raw[p*NB+k] : m_btn[p*NB+k];
                        m_primed[p] = 1'b1;
                    end
                    m_raw = raw;
`endif
                    check("buttons", buttons, nb);
                    check("pressed", pressed, nb & ~m_btn);
                    check("latency", cyc - start_cyc, LAT);
                    check("pulses", pulses, NB - 1);
                    check("busy_at_valid", busy, 0);
                    m_btn = nb;
                end
            end
            latch_prev = pad_latch; pulse_prev = pad_pulse;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(input int target);
        for (int i = 0; i < 3000 && nvalid < target; i++) tick();
        check("valid_timeout", nvalid, target);
    endtask

    task automatic frame(input logic [W-1:0] h);
        int n0 = nvalid;
        held = h;
        poll_now = 1'b1; tick(); poll_now = 1'b0;
        wait_valid(n0 + 1);
    endtask

    initial begin
        int v1, n0, f0;
        tick();
        check("rst_latch", pad_latch, 0);
        check("rst_pulse", pad_pulse, 0);
        check("rst_buttons", buttons, 0);
        check("rst_pressed", pressed, 0);
        check("rst_valid", buttons_valid, 0);
        check("rst_busy", busy, 0);
        reset_n = 1'b1;
        repeat (3) tick();

        frame('0);
        frame(16'h8001);
        frame(16'h8001);
        frame('0);
        frame(16'h0004);
        frame('0);
        frame(16'h0004);
        frame(16'h0004);
        frame('0);

        n0 = nvalid; f0 = frames;
        held = 16'h5a3c;
        poll_now = 1'b1; tick(); poll_now = 1'b0;
        repeat (6) tick();
        check("busy_in_frame", busy, 1);
        poll_now = 1'b1; tick(); poll_now = 1'b0;
        repeat (4) tick();
        poll_now = 1'b1; tick(); poll_now = 1'b0;
        wait_valid(n0 + 1);
        v1 = valid_cyc;
        wait_valid(n0 + 2);
        check("requeue_gap", start_cyc - v1, 1);
        repeat (60) tick();
        check("one_extra_frame", frames - f0, 2);

        held = 16'h0ff0;
        poll_now = 1'b1; tick(); poll_now = 1'b0;
        for (int i = 0; i < 200 && !(pad_pulse && pulses == 3); i++) tick();
        check("reached_bit3", pad_pulse && pulses == 3, 1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_latch", pad_latch, 0);
        check("mid_rst_pulse", pad_pulse, 0);
        check("mid_rst_buttons", buttons, 0);
        check("mid_rst_busy", busy, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_rst_no_valid", buttons_valid, 0);
        end
        reset_n = 1'b1;
        held = 16'h1234;
        poll_en = 1'b1;
        wait_valid(nvalid + 1);

        n0 = nvalid;
        for (int i = 0; i < 8000 && nvalid < n0 + 10; i++) begin
            if (nvalid != n0 && buttons_valid) held = W'($urandom);
            poll_now = ($urandom_range(0, 40) == 0);
            tick();
        end
        poll_now = 1'b0;
        check("random_frames", nvalid >= n0 + 10, 1);
        poll_en = 1'b0;
        repeat (80) tick();
        check("queue_drained", expq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
